// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: prescaled or single-stepped static/rotate/bounce/blink patterns.
// Optional blink mode is enabled by defining LED_PATTERN_SCHED_BLINK_EN.
module led_pattern_sched #(
    parameter int TICK_DIV = 12500000,
    parameter int LED_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic [LED_W-1:0] pat_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             pause_i,
    input  logic             step_i,
    output logic [LED_W-1:0] led_o,
    output logic             tick_o
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             dir_q, dir_d;    // 0 = left, 1 = right
    logic [1:0]       mode_q;
`ifdef LED_PATTERN_SCHED_BLINK_EN
    logic             phase_q, phase_d;
`endif

    logic run_tick, load_fire, step_evt, mode_chg, msb, lsb;

    assign run_tick     = (state_q == RUN) && (cnt_q == TERM);
    assign load_ready_o = (state_q != RUN) || run_tick;
    assign load_fire    = load_valid_i && load_ready_o;
    assign step_evt     = run_tick || ((state_q == HOLD) && step_i);
    assign tick_o       = step_evt && !load_fire && !rst;
    assign mode_chg     = (mode_i != mode_q);
    assign msb          = pat_q[LED_W-1];
    assign lsb          = pat_q[0];
    assign led_o        = led_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        dir_d   = mode_chg ? 1'b0 : dir_q;
`ifdef LED_PATTERN_SCHED_BLINK_EN
        phase_d = mode_chg ? 1'b0 : phase_q;
`endif

        case (state_q)
            IDLE:    if (load_fire) state_d = pause_i ? HOLD : RUN;
            RUN:     if (pause_i) state_d = HOLD;
            HOLD:    if (!pause_i) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (state_q == RUN) cnt_d = run_tick ? '0 : cnt_q + 1'b1;

        if (load_fire) begin
            pat_d = pat_i;
            cnt_d = '0;
            dir_d = 1'b0;
`ifdef LED_PATTERN_SCHED_BLINK_EN
            phase_d = 1'b0;
`endif
        end else if (step_evt) begin
            case (mode_i)
                2'b01: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                2'b10: begin
                    // A pattern touching both ends cannot move either way, so it holds.
                    if (!(msb && lsb)) begin
                        if (!dir_d) begin
                            if (msb) begin
                                dir_d = 1'b1;
                                pat_d = pat_q >> 1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (lsb) begin
                                dir_d = 1'b0;
                                pat_d = pat_q << 1;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                end
`ifdef LED_PATTERN_SCHED_BLINK_EN
                2'b11:   phase_d = ~phase_d;
`endif
                default: ;
            endcase
        end

`ifdef LED_PATTERN_SCHED_BLINK_EN
        led_d = phase_d ? '0 : pat_d;
`else
        led_d = pat_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            led_q   <= '0;
            dir_q   <= 1'b0;
`ifdef LED_PATTERN_SCHED_BLINK_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
`ifdef LED_PATTERN_SCHED_BLINK_EN
            phase_q <= phase_d;
`endif
        end
    end

    // NOTE: mode_q only tracks the previous mode and is never read under reset, so it needs no reset.
    always_ff @(posedge clk) begin
        mode_q <= mode_i;
    end

endmodule
